// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI byte serializer between the hash-result
// requester (0) and the status/control requester (1). A whole frame of
// FRAME_BYTES bytes is granted to one requester, each byte is handed to the
// serializer over a start/done handshake, and an idle gap of GAP_CYCLES
// clocks separates frames before round-robin re-arbitration.
module spi_tx_arbiter #(
  parameter int FRAME_BYTES = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] ser_data,
  output logic       ser_start,
  input  logic       ser_done,
  output logic       frame_en,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err_stray_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  // Index of the last byte in a frame, and the gap counter load value
  // (the gap counter counts down to zero, so it starts one below the length).
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] ser_data_q, ser_data_d;
  logic       err_stray_q, err_stray_d;

  logic       granted_valid;
  logic [7:0] granted_data;

  assign granted_valid = (grant_q[0] & req0_valid) | (grant_q[1] & req1_valid);
  assign granted_data  = grant_q[1] ? req1_data : req0_data;

  // Next-state logic: arbitration in IDLE, byte handshake in LOAD, serializer
  // start/done sequencing, and the inter-frame gap countdown.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_data_d  = ser_data_q;
    err_stray_d = err_stray_q;

    if (ser_done && (state_q != ST_WAIT)) begin
      err_stray_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) begin
            grant_d = rr_ptr_q ? 2'b10 : 2'b01;
          end else if (req0_valid) begin
            grant_d = 2'b01;
          end else begin
            grant_d = 2'b10;
          end
          byte_cnt_d = 4'd0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (granted_valid) begin
          ser_data_d = granted_data;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ser_done) begin
          if (byte_cnt_q == LAST_BYTE) begin
            rr_ptr_d   = grant_q[0];
            grant_d    = 2'b00;
            byte_cnt_d = 4'd0;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              gap_cnt_d = GAP_LOAD;
              state_d   = ST_GAP;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      rr_ptr_q    <= 1'b0;
      byte_cnt_q  <= 4'd0;
      gap_cnt_q   <= 8'd0;
      ser_data_q  <= 8'h00;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_data_q  <= ser_data_d;
      err_stray_q <= err_stray_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  // combinationally.
  assign req0_ready     = (state_q == ST_LOAD) & grant_q[0];
  assign req1_ready     = (state_q == ST_LOAD) & grant_q[1];
  assign ser_data       = ser_data_q;
  assign ser_start      = (state_q == ST_SEND);
  assign frame_en       = (state_q == ST_SEND) | (state_q == ST_WAIT) |
                          ((state_q == ST_LOAD) & (byte_cnt_q != 4'd0));
  assign grant          = grant_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_stray_done = err_stray_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: scoreboard bench for spi_tx_arbiter. Instance A uses
// FRAME_BYTES=4 / GAP_CYCLES=8 with a serializer model; instance B uses
// FRAME_BYTES=1 / GAP_CYCLES=0 and is driven by hand for back-to-back timing.
module tb_spi_tx_arbiter;

   typedef struct packed {
      logic       owner;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Instance A signals
   logic       aReq0Valid, aReq0Ready, aReq1Valid, aReq1Ready;
   logic [7:0] aReq0Data, aReq1Data, aSerData;
   logic       aSerStart, aSerDone, aFrameEn, aBusy, aErr;
   logic [1:0] aGrant;
   logic       modelDone, strayDone;

   // Instance B signals
   logic       bReq0Valid, bReq0Ready, bReq1Valid, bReq1Ready;
   logic [7:0] bReq0Data, bReq1Data, bSerData;
   logic       bSerStart, bSerDone, bFrameEn, bBusy, bErr;
   logic [1:0] bGrant;

   int   vectors = 0;
   int   miscompares = 0;
   int   startCount = 0;
   exp_t expQ[$];
   logic [7:0] srcQ0[$];
   logic [7:0] srcQ1[$];

   assign aSerDone = modelDone | strayDone;

   // 100 MHz clock.
   always #5 clk = ~clk;

   spi_tx_arbiter #(.FRAME_BYTES(4), .GAP_CYCLES(8)) dutA (
      .clk(clk), .rst(rst),
      .req0_valid(aReq0Valid), .req0_data(aReq0Data), .req0_ready(aReq0Ready),
      .req1_valid(aReq1Valid), .req1_data(aReq1Data), .req1_ready(aReq1Ready),
      .ser_data(aSerData), .ser_start(aSerStart), .ser_done(aSerDone),
      .frame_en(aFrameEn), .grant(aGrant), .busy(aBusy), .err_stray_done(aErr)
   );

   spi_tx_arbiter #(.FRAME_BYTES(1), .GAP_CYCLES(0)) dutB (
      .clk(clk), .rst(rst),
      .req0_valid(bReq0Valid), .req0_data(bReq0Data), .req0_ready(bReq0Ready),
      .req1_valid(bReq1Valid), .req1_data(bReq1Data), .req1_ready(bReq1Ready),
      .ser_data(bSerData), .ser_start(bSerStart), .ser_done(bSerDone),
      .frame_en(bFrameEn), .grant(bGrant), .busy(bBusy), .err_stray_done(bErr)
   );

   // Every comparison goes through here so the counters stay in one place.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Queue a byte at a requester and, when asked, its expected appearance
   // at the serializer in grant order.
   task automatic applyStimulus(input logic req, input logic [7:0] data, input logic withExp);
      if (req) srcQ1.push_back(data);
      else     srcQ0.push_back(data);
      if (withExp) expQ.push_back('{owner: req, data: data});
   endtask

   task automatic expectByte(input logic req, input logic [7:0] data);
      expQ.push_back('{owner: req, data: data});
   endtask

   task automatic applyFrame(input logic req, input logic [7:0] first);
      for (int i = 0; i < 4; i++) applyStimulus(req, first + 8'(i), 1'b1);
   endtask

   function automatic logic [31:0] outsA();
      return {16'h0, aSerData, aSerStart, aFrameEn, aGrant, aBusy, aErr, aReq0Ready, aReq1Ready};
   endfunction

   function automatic logic [31:0] outsB();
      return {16'h0, bSerData, bSerStart, bFrameEn, bGrant, bBusy, bErr, bReq0Ready, bReq1Ready};
   endfunction

   // Wait until every expected byte has been started and A has gone idle.
   task automatic waitIdle(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((expQ.size() != 0 || aBusy) && n < budget);
      checkOutput({name, "_queue_drained"}, expQ.size(), 0);
      checkOutput({name, "_idle"}, 32'(aBusy), 0);
   endtask

   task automatic waitStarts(input int target, input int budget, input string name);
      int n = 0;
      while (startCount < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, startCount, target);
   endtask

   // Requester drivers: valid while a requester's queue holds bytes; a byte
   // leaves the queue after the clock edge that saw valid & ready.
   initial begin
      bit hs0, hs1;
      aReq0Valid = 1'b0; aReq0Data = 8'h00;
      aReq1Valid = 1'b0; aReq1Data = 8'h00;
      forever begin
         @(negedge clk);
         hs0 = aReq0Valid & aReq0Ready;
         hs1 = aReq1Valid & aReq1Ready;
         @(posedge clk);
         #1;
         if (hs0 && srcQ0.size() != 0) void'(srcQ0.pop_front());
         if (hs1 && srcQ1.size() != 0) void'(srcQ1.pop_front());
         aReq0Valid = (srcQ0.size() != 0);
         aReq0Data  = (srcQ0.size() != 0) ? srcQ0[0] : 8'h00;
         aReq1Valid = (srcQ1.size() != 0);
         aReq1Data  = (srcQ1.size() != 0) ? srcQ1[0] : 8'h00;
      end
   end

   // Serializer model for A: done pulse about 8 cycles after each start,
   // abandoned if reset arrives while shifting.
   initial begin
      bit aborted;
      modelDone = 1'b0;
      forever begin
         @(negedge clk);
         if (aSerStart && !rst) begin
            aborted = 1'b0;
            for (int i = 0; i < 8 && !aborted; i++) begin
               @(negedge clk);
               if (rst) aborted = 1'b1;
            end
            if (!aborted) begin
               @(posedge clk); #1 modelDone = 1'b1;
               @(posedge clk); #1 modelDone = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each ser_start, holds frame_en/grant/
   // ready expectations across a frame, then checks the 8-cycle gap and the
   // return to idle.
   initial begin
      bit   inFrame;
      bit   checkIdle;
      logic owner;
      int   doneCnt;
      int   gapLeft;
      exp_t e;
      inFrame = 0; checkIdle = 0; owner = 1'b0; doneCnt = 0; gapLeft = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            inFrame = 0; checkIdle = 0; doneCnt = 0; gapLeft = 0;
         end else begin
            if (aSerStart) begin
               startCount++;
               if (expQ.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_start: got start with data 0x%0h grant 0x%0h, want no start", aSerData, aGrant);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("ser_data", 32'(aSerData), 32'(e.data));
                  checkOutput("grant_at_start", 32'(aGrant), e.owner ? 2 : 1);
                  owner = e.owner;
               end
               inFrame = 1;
            end
            if (inFrame) begin
               checkOutput("frame_en_in_frame", 32'(aFrameEn), 1);
               checkOutput("grant_in_frame", 32'(aGrant), owner ? 2 : 1);
               checkOutput("other_ready_low", 32'(owner ? aReq0Ready : aReq1Ready), 0);
            end else if (gapLeft > 0) begin
               checkOutput("gap_outputs", 32'({aFrameEn, aGrant, aBusy, aReq0Ready, aReq1Ready, aSerStart}), 'h08);
               gapLeft--;
               checkIdle = (gapLeft == 0);
            end else if (checkIdle) begin
               checkOutput("idle_after_gap", 32'(aBusy), 0);
               checkIdle = 0;
            end
            if (inFrame && modelDone) begin
               doneCnt++;
               if (doneCnt == 4) begin
                  inFrame = 0;
                  doneCnt = 0;
                  gapLeft = 8;
               end
            end
         end
      end
   end

   // Watchdog so a wedged run still ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int n;
      int lowCycles;
      int base;
      strayDone = 1'b0;
      bReq0Valid = 1'b0; bReq0Data = 8'h00;
      bReq1Valid = 1'b0; bReq1Data = 8'h00;
      bSerDone = 1'b0;

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_outputs_a", outsA(), 0);
      checkOutput("reset_outputs_b", outsB(), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Single requester frame A1..D4.
      applyStimulus(1'b0, 8'hA1, 1'b1);
      applyStimulus(1'b0, 8'hB2, 1'b1);
      applyStimulus(1'b0, 8'hC3, 1'b1);
      applyStimulus(1'b0, 8'hD4, 1'b1);
      waitIdle(300, "single_frame");

      // Reset so contention starts with priority on requester 0.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      applyFrame(1'b0, 8'h10);
      applyFrame(1'b1, 8'h20);
      applyFrame(1'b0, 8'h14);
      applyFrame(1'b1, 8'h24);
      waitIdle(600, "contention");
      checkOutput("err_clear_before_stray", 32'(aErr), 0);

      // Stray done while idle.
      @(posedge clk); #1 strayDone = 1'b1;
      @(posedge clk); #1 strayDone = 1'b0;
      @(negedge clk);
      checkOutput("err_after_idle_stray", 32'(aErr), 1);
      checkOutput("idle_after_stray", 32'(aBusy), 0);

      // Requester 0 stalls after two bytes while requester 1 waits.
      applyStimulus(1'b0, 8'h31, 1'b1);
      applyStimulus(1'b0, 8'h32, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h41 + 8'(i), 1'b0);
      n = 0;
      while (srcQ0.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("stall_first_two_taken", srcQ0.size(), 0);
      repeat (20) @(negedge clk);
      checkOutput("stall_in_load", 32'({aGrant, aReq0Ready, aReq1Ready, aFrameEn, aSerStart}), 'h1A);
      @(posedge clk); #1 strayDone = 1'b1;
      @(posedge clk); #1 strayDone = 1'b0;
      @(negedge clk);
      checkOutput("stall_after_load_stray", 32'({aGrant, aReq0Ready, aReq1Ready, aFrameEn, aSerStart}), 'h1A);
      applyStimulus(1'b0, 8'h33, 1'b1);
      applyStimulus(1'b0, 8'h34, 1'b1);
      for (int i = 0; i < 4; i++) expectByte(1'b1, 8'h41 + 8'(i));
      waitIdle(600, "stall");
      checkOutput("err_sticky", 32'(aErr), 1);

      // Reset during WAIT of byte 3 in the second of two requester 0 frames.
      base = startCount;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h50 + 8'(i), 1'b1);
      waitStarts(base + 7, 400, "reach_byte3_frame2");
      @(posedge clk); #2 rst = 1'b1;
      #1 checkOutput("reset_mid_frame", outsA(), 0);
      srcQ0.delete();
      expQ.delete();
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("err_cleared_by_reset", 32'(aErr), 0);
      applyFrame(1'b0, 8'h71);
      applyFrame(1'b1, 8'h81);
      waitIdle(600, "after_reset");

      // Instance B: single-byte frames, no gap.
      @(posedge clk); #1 bReq0Valid = 1'b1; bReq0Data = 8'h5A;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bSerStart && n < 20);
      checkOutput("b_first_latency", n, 3);
      checkOutput("b_first_data", 32'(bSerData), 'h5A);
      checkOutput("b_first_grant", 32'(bGrant), 1);
      @(posedge clk); #1 bReq0Data = 8'h6B; bSerDone = 1'b1;
      @(negedge clk);
      checkOutput("b_data_held_in_wait", 32'(bSerData), 'h5A);
      @(posedge clk); #1 bSerDone = 1'b0;
      n = 0;
      lowCycles = 0;
      do begin
         @(negedge clk);
         n++;
         if (!bFrameEn) lowCycles++;
      end while (!bSerStart && n < 10);
      checkOutput("b_done_to_start", n, 3);
      checkOutput("b_frame_en_dropped", 32'(lowCycles > 0), 1);
      checkOutput("b_second_data", 32'(bSerData), 'h6B);
      checkOutput("b_no_stray", 32'(bErr), 0);
      @(posedge clk); #1 bReq0Valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
